// File: rtl/factorial_seq.sv
// Sequential n! engine: one multiply per cycle for 2<=n<=8; small and overflowing
// operands go straight to DONE. Valid/ready handshake on both sides, no bypass.
module factorial_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] fact,
    output logic        ovf
);

    // state | meaning
    // IDLE  | waiting for an operand, in_ready high once out of reset
    // CALC  | one acc*cnt multiply per cycle, cnt counting down to 2
    // DONE  | result presented, held until downstream takes it
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] fact_q, fact_d;
    logic        ovf_q, ovf_d;
    logic [15:0] prod;
    logic        accept;

    // Truncation to 16 bits is intended; it never bites for n<=8.
    assign prod   = acc_q * {12'd0, cnt_q};
    assign accept = in_ready && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            fact_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            fact_q  <= fact_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fact_d  = fact_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (n <= 4'd1) begin
                        fact_d  = 16'h0001;
                        ovf_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (n >= 4'd9) begin
                        fact_d  = 16'hFFFF;
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = 16'h0001;
                        cnt_d   = n;
                        ovf_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = prod;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd2) begin
                    fact_d  = prod;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // armed_q keeps in_ready low while reset is held, even though state is IDLE.
    always_comb begin
        in_ready  = armed_q && (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        fact      = fact_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_factorial_seq.sv
// Bench for factorial_seq: directed operands, a protocol-level reference model
// compared every cycle, plus literal expectations per operation.
module tb_factorial_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  n_i = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] fact;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    factorial_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fact      (fact),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fact_of(input int k);
        int f = 1;
        for (int i = 2; i <= k; i++) f = f * i;
        return (f > 65535) ? 16'hFFFF : f[15:0];
    endfunction

    // Reference model: phase 0=idle, 1=busy, 2=holding result.
    int          m_phase = 0;
    int          m_left = 0;
    logic        m_armed = 1'b0;
    logic [15:0] m_fact = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_armed <= 1'b0;
            m_fact  <= 16'h0;
            m_ovf   <= 1'b0;
        end else begin
            m_armed <= 1'b1;
            case (m_phase)
                0: if (m_armed && in_valid) begin
                    if (n_i <= 1 || n_i >= 9) begin
                        m_phase <= 2;
                        m_fact  <= fact_of(int'(n_i));
                        m_ovf   <= (n_i >= 9);
                    end else begin
                        m_phase <= 1;
                        m_left  <= int'(n_i) - 1;
                        m_pend  <= fact_of(int'(n_i));
                        m_ovf   <= 1'b0;
                    end
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_fact  <= m_pend;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", in_ready, (m_phase == 0) && m_armed);
            chk("model_out_valid", out_valid, m_phase == 2);
            chk("model_fact", fact, m_fact);
            chk("model_ovf", ovf, m_ovf);
        end
    end

    task automatic run_op(input logic [3:0] nv, input int hold, input bit noise,
                          input logic [15:0] exp_fact, input logic exp_ovf, input int exp_calc);
        int c = 0;
        while (!in_ready && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("ready_wait", in_ready, 1);
        out_ready = (hold == 0);
        n_i = nv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", in_ready, 0);
        if (noise) n_i = 4'd15;
        else begin
            in_valid = 1'b0;
            n_i = 4'($urandom);
        end
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 40) begin
            c++;
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        n_i = 4'($urandom);
        chk("calc_cycles", c, exp_calc);
        chk("result_fact", fact, exp_fact);
        chk("result_ovf", ovf, exp_ovf);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("held_valid", out_valid, 1);
            chk("held_fact", fact, exp_fact);
            chk("held_ovf", ovf, exp_ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_handoff", in_ready, 1);
        chk("fact_retained", fact, exp_fact);
    endtask

    initial begin
        #1 chk("reset_in_ready", in_ready, 0);
        chk("reset_fact", fact, 0);
        chk("reset_out_valid", out_valid, 0);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_first_edge", in_ready, 1);

        run_op(4'd0,  0, 1'b0, 16'h0001, 1'b0, 0);
        run_op(4'd1,  0, 1'b0, 16'h0001, 1'b0, 0);
        run_op(4'd5,  0, 1'b0, 16'h0078, 1'b0, 4);
        run_op(4'd8,  0, 1'b0, 16'h9D80, 1'b0, 7);
        run_op(4'd3,  0, 1'b0, 16'h0006, 1'b0, 2);
        run_op(4'd9,  0, 1'b0, 16'hFFFF, 1'b1, 0);
        run_op(4'd15, 0, 1'b0, 16'hFFFF, 1'b1, 0);
        run_op(4'd4,  3, 1'b1, 16'h0018, 1'b0, 3);
        run_op(4'd6,  1, 1'b0, 16'h02D0, 1'b0, 5);

        // Reset in the third CALC cycle of 7!
        n_i = 4'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_fact", fact, 0);
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op(4'd2, 0, 1'b0, 16'h0002, 1'b0, 1);

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
